// File: rtl/ssd1306_spi_decoder.sv
// SSD1306-compatible SPI slave: synchronises the SPI pins, assembles bytes and
// decodes commands into control registers and auto-incrementing GDDRAM writes.
module ssd1306_spi_decoder #(
  parameter int unsigned COLUMNS = 128,
  parameter int unsigned PAGES   = 8,
  localparam int unsigned ADDR_W = $clog2(COLUMNS) + $clog2(PAGES)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CS_i,
  input  logic              SCK_i,
  input  logic              MOSI_i,
  input  logic              DC_i,
  output logic [ADDR_W-1:0] MemAddr_o,
  output logic [7:0]        MemData_o,
  output logic              MemWrite_o,
  output logic              DisplayOn_o,
  output logic [7:0]        Contrast_o,
  output logic              Invert_o
);

  localparam int unsigned COL_W  = $clog2(COLUMNS);
  localparam int unsigned PAGE_W = $clog2(PAGES);

  localparam logic [1:0] MODE_H = 2'b00;
  localparam logic [1:0] MODE_V = 2'b01;
  localparam logic [1:0] MODE_P = 2'b10;

  typedef enum logic [1:0] {CMD, ARG1, ARG2} dec_state_t;

  logic [1:0]        cs_s, sck_s, mosi_s, dc_s;
  logic              sck_d;
  logic [2:0]        bit_cnt;
  logic [6:0]        shreg;
  logic              byte_stb;
  logic [7:0]        rx_byte;
  logic              rx_dc;

  dec_state_t        state;
  logic [7:0]        cmd;
  logic [7:0]        arg_start;
  logic [1:0]        mode;
  logic [COL_W-1:0]  col, col_start, col_end, col_nxt;
  logic [PAGE_W-1:0] page, page_start, page_end, page_nxt;
  logic [7:0]        col8;
  logic [COL_W-1:0]  rng_col_lo, rng_col_hi;
  logic [PAGE_W-1:0] rng_page_lo, rng_page_hi;
  logic              sck_rise;

  function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] v);
    return (9'(v) > 9'(COLUMNS - 1)) ? COL_W'(COLUMNS - 1) : COL_W'(v);
  endfunction

  function automatic logic [PAGE_W-1:0] clamp_page(input logic [7:0] v);
    return (9'(v) > 9'(PAGES - 1)) ? PAGE_W'(PAGES - 1) : PAGE_W'(v);
  endfunction

  assign sck_rise = sck_s[1] & ~sck_d;
  assign col8     = 8'(col);

  // Range arguments: clamp both ends, then never let end fall below start.
  always_comb begin
    rng_col_lo  = clamp_col(arg_start);
    rng_col_hi  = clamp_col(rx_byte);
    rng_page_lo = clamp_page(arg_start);
    rng_page_hi = clamp_page(rx_byte);
    if (rng_col_hi < rng_col_lo)   rng_col_hi  = rng_col_lo;
    if (rng_page_hi < rng_page_lo) rng_page_hi = rng_page_lo;
  end

  // Pointer advance after a data write, per addressing mode.
  always_comb begin
    col_nxt  = col;
    page_nxt = page;
    case (mode)
      MODE_H: begin
        if (col == col_end) begin
          col_nxt  = col_start;
          page_nxt = (page == page_end) ? page_start : page + PAGE_W'(1);
        end else begin
          col_nxt = col + COL_W'(1);
        end
      end
      MODE_V: begin
        if (page == page_end) begin
          page_nxt = page_start;
          col_nxt  = (col == col_end) ? col_start : col + COL_W'(1);
        end else begin
          page_nxt = page + PAGE_W'(1);
        end
      end
      default: col_nxt = (col == col_end) ? col_start : col + COL_W'(1);
    endcase
  end

  // SPI front end: synchronisers, SCK edge detect and byte assembly.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cs_s     <= 2'b11;
      sck_s    <= 2'b00;
      mosi_s   <= 2'b00;
      dc_s     <= 2'b00;
      sck_d    <= 1'b0;
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      byte_stb <= 1'b0;
      rx_byte  <= 8'd0;
      rx_dc    <= 1'b0;
    end else begin
      cs_s     <= {cs_s[0], CS_i};
      sck_s    <= {sck_s[0], SCK_i};
      mosi_s   <= {mosi_s[0], MOSI_i};
      dc_s     <= {dc_s[0], DC_i};
      sck_d    <= sck_s[1];
      byte_stb <= 1'b0;
      if (cs_s[1]) begin
        bit_cnt <= 3'd0;
      end else if (sck_rise) begin
        shreg   <= {shreg[5:0], mosi_s[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_stb <= 1'b1;
          rx_byte  <= {shreg, mosi_s[1]};
          rx_dc    <= dc_s[1];
        end
      end
    end
  end

  // Command decoder and framebuffer write generation.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= CMD;
      cmd         <= 8'd0;
      arg_start   <= 8'd0;
      mode        <= MODE_P;
      col         <= '0;
      page        <= '0;
      col_start   <= '0;
      col_end     <= COL_W'(COLUMNS - 1);
      page_start  <= '0;
      page_end    <= PAGE_W'(PAGES - 1);
      MemAddr_o   <= '0;
      MemData_o   <= 8'd0;
      MemWrite_o  <= 1'b0;
      DisplayOn_o <= 1'b0;
      Contrast_o  <= 8'h7F;
      Invert_o    <= 1'b0;
    end else begin
      MemWrite_o <= 1'b0;
      if (byte_stb) begin
        if (rx_dc) begin
          state      <= CMD;
          MemWrite_o <= 1'b1;
          MemData_o  <= rx_byte;
          MemAddr_o  <= {page, col};
          col        <= col_nxt;
          page       <= page_nxt;
        end else begin
          case (state)
            CMD: begin
              case (rx_byte[7:4])
                4'h0: col  <= COL_W'({col8[7:4], rx_byte[3:0]});
                4'h1: col  <= COL_W'({rx_byte[3:0], col8[3:0]});
                4'hB: page <= clamp_page({4'h0, rx_byte[3:0]});
                default: begin
                  case (rx_byte)
                    8'hAE, 8'hAF: DisplayOn_o <= rx_byte[0];
                    8'hA6, 8'hA7: Invert_o    <= rx_byte[0];
                    8'h20, 8'h81, 8'h21, 8'h22: begin
                      cmd   <= rx_byte;
                      state <= ARG1;
                    end
                    default: ;
                  endcase
                end
              endcase
            end
            ARG1: begin
              state <= CMD;
              case (cmd)
                8'h20: if (rx_byte[1:0] != 2'b11) mode <= rx_byte[1:0];
                8'h81: Contrast_o <= rx_byte;
                default: begin
                  arg_start <= rx_byte;
                  state     <= ARG2;
                end
              endcase
            end
            default: begin
              state <= CMD;
              if (cmd == 8'h21) begin
                col_start <= rng_col_lo;
                col_end   <= rng_col_hi;
                col       <= rng_col_lo;
              end else begin
                page_start <= rng_page_lo;
                page_end   <= rng_page_hi;
                page       <= rng_page_lo;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_decoder.sv
// Randomised bench for ssd1306_spi_decoder: a byte-level reference model feeds
// an expected-write queue that a monitor drains on every MemWrite_o pulse.
module tb_ssd1306_spi_decoder;

  localparam int unsigned COLUMNS = 128;
  localparam int unsigned PAGES   = 8;
  localparam int unsigned ADDR_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs, sck, mosi, dc;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_write;
  logic              disp_on;
  logic [7:0]        contrast;
  logic              invert;

  always #5 clk = ~clk;

  ssd1306_spi_decoder #(.COLUMNS(COLUMNS), .PAGES(PAGES)) dut (
    .Clock(clk), .Reset(rst_n), .CS_i(cs), .SCK_i(sck), .MOSI_i(mosi), .DC_i(dc),
    .MemAddr_o(mem_addr), .MemData_o(mem_data), .MemWrite_o(mem_write),
    .DisplayOn_o(disp_on), .Contrast_o(contrast), .Invert_o(invert)
  );

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers, ranges inclusive)
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  int m_contrast, m_disp, m_inv, m_pend, m_have_arg, m_arg0;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_mode = 2; m_col = 0; m_page = 0;
    m_cs = 0; m_ce = COLUMNS - 1; m_ps = 0; m_pe = PAGES - 1;
    m_contrast = 8'h7F; m_disp = 0; m_inv = 0;
    m_pend = -1; m_have_arg = 0; m_arg0 = 0;
  endtask

  task automatic model_advance();
    if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % COLUMNS;
      end else m_page = (m_page + 1) % PAGES;
    end else begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        if (m_mode == 0) m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
      end else m_col = (m_col + 1) % COLUMNS;
    end
  endtask

  task automatic model_byte(input int b, input bit is_data);
    int s, e;
    if (is_data) begin
      m_pend = -1; m_have_arg = 0;
      exp_q.push_back('{m_page * COLUMNS + m_col, b});
      model_advance();
    end else if (m_pend < 0) begin
      if ((b >> 4) == 0)        m_col = (m_col & 'hF0) | (b & 15);
      else if ((b >> 4) == 1)   m_col = (((b & 15) << 4) | (m_col & 15)) % COLUMNS;
      else if ((b >> 4) == 'hB) m_page = min2(b & 15, PAGES - 1);
      else if (b == 'hAE || b == 'hAF) m_disp = b & 1;
      else if (b == 'hA6 || b == 'hA7) m_inv = b & 1;
      else if (b == 'h20 || b == 'h81 || b == 'h21 || b == 'h22) begin
        m_pend = b; m_have_arg = 0;
      end
    end else if (m_pend == 'h20) begin
      if ((b & 3) != 3) m_mode = b & 3;
      m_pend = -1;
    end else if (m_pend == 'h81) begin
      m_contrast = b; m_pend = -1;
    end else if (!m_have_arg) begin
      m_arg0 = b; m_have_arg = 1;
    end else begin
      if (m_pend == 'h21) begin
        s = min2(m_arg0, COLUMNS - 1); e = min2(b, COLUMNS - 1);
        if (e < s) e = s;
        m_cs = s; m_ce = e; m_col = s;
      end else begin
        s = min2(m_arg0, PAGES - 1); e = min2(b, PAGES - 1);
        if (e < s) e = s;
        m_ps = s; m_pe = e; m_page = s;
      end
      m_pend = -1; m_have_arg = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7 - i];
      dc   = d;
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    model_byte(int'(b), d);
    send_bits(b, d, 8);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk({tag, "_display_on"}, int'(disp_on), m_disp);
    chk({tag, "_contrast"}, int'(contrast), m_contrast);
    chk({tag, "_invert"}, int'(invert), m_inv);
    chk({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (int'(mem_addr) != e.addr || int'(mem_data) != e.data) begin
          errors++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_data, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    logic [7:0] rb;
    int kind;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_memwrite", int'(mem_write), 0);
    chk("reset_contrast", int'(contrast), 'h7F);
    chk("reset_display_on", int'(disp_on), 0);
    chk("reset_invert", int'(invert), 0);
    chk("reset_memaddr", int'(mem_addr), 0);
    chk("reset_memdata", int'(mem_data), 0);

    cs = 1'b0;
    repeat (4) @(posedge clk);

    send_byte(8'hAF, 0); send_byte(8'h81, 0); send_byte(8'h33, 0); send_byte(8'hA7, 0);
    settle_and_check("ctrl");
    chk("ctrl_contrast_const", int'(contrast), 'h33);

    send_byte(8'h20, 0); send_byte(8'h00, 0);
    send_byte(8'h21, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    send_byte(8'h22, 0); send_byte(8'h06, 0); send_byte(8'h07, 0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1);
    settle_and_check("horiz");
    chk("horiz_last_addr", int'(mem_addr), 6 * COLUMNS + 126);

    send_byte(8'h20, 0); send_byte(8'h01, 0);
    send_byte(8'h21, 0); send_byte(8'h00, 0); send_byte(8'hFF, 0);
    send_byte(8'h22, 0); send_byte(8'h00, 0); send_byte(8'h0F, 0);
    for (int i = 0; i < 9; i++) send_byte(8'(8'h40 + i), 1);
    settle_and_check("vert");
    chk("vert_last_addr", int'(mem_addr), 0 * COLUMNS + 1);

    send_byte(8'h20, 0); send_byte(8'h02, 0);
    send_byte(8'hB3, 0); send_byte(8'h0F, 0); send_byte(8'h17, 0);
    send_byte(8'hC1, 1); send_byte(8'hC2, 1);
    settle_and_check("page");
    chk("page_last_addr", int'(mem_addr), 3 * COLUMNS + 0);

    send_bits(8'h3C, 1'b1, 5);
    cs = 1'b1;
    repeat (8) @(posedge clk);
    cs = 1'b0;
    repeat (4) @(posedge clk);
    send_byte(8'hA5, 1);
    settle_and_check("partial");
    chk("partial_data", int'(mem_data), 'hA5);
    send_byte(8'h21, 0); send_byte(8'h5A, 1); send_byte(8'h5B, 1);
    settle_and_check("abort");

    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        send_byte(8'($urandom), 1);
      end else if (kind == 9 && $urandom_range(0, 3) == 0) begin
        send_bits(8'($urandom), 1'($urandom), int'($urandom_range(1, 7)));
        cs = 1'b1;
        repeat (6) @(posedge clk);
        cs = 1'b0;
        repeat (4) @(posedge clk);
      end else begin
        case ($urandom_range(0, 7))
          0: rb = 8'($urandom_range(8'h00, 8'h1F));
          1: rb = 8'($urandom_range(8'hB0, 8'hBF));
          2: rb = 8'($urandom_range(8'hAE, 8'hAF));
          3: rb = 8'($urandom_range(8'hA6, 8'hA7));
          4: rb = 8'h20;
          5: rb = 8'h81;
          6: rb = ($urandom_range(0, 1) == 0) ? 8'h21 : 8'h22;
          default: rb = 8'($urandom);
        endcase
        send_byte(rb, 0);
      end
      if (n % 50 == 49) settle_and_check("random");
    end
    settle_and_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_decoder.md
Name: ssd1306_spi_decoder

Overview:
Parametrised SSD1306-compatible SPI slave and command decoder for the display-replica path. It receives bytes on CS/SCK/MOSI/DC, interprets the command set, and emits single-cycle framebuffer write strobes with auto-incremented GDDRAM addresses. It supports a configurable panel geometry and all three SSD1306 addressing modes, and feeds the VGA scan-out framebuffer and its control register inputs.

Parameters:
COLUMNS, 128, number of columns per page (power of two, 16..256)
PAGES, 8, number of 8-pixel-high pages (power of two, 2..16)
(derived) COL_W = clog2(COLUMNS), PAGE_W = clog2(PAGES), ADDR_W = COL_W + PAGE_W

Ports:
Clock  in  1  system clock (SCK_i ≤ Clock/8)
Reset  in  1  synchronous reset, active low
CS_i  in  1  SPI chip select, active low, asynchronous to Clock
SCK_i  in  1  SPI clock, mode 0, asynchronous
MOSI_i  in  1  SPI data, MSB first
DC_i  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of the byte
MemAddr_o  out  ADDR_W  write address = {page, column}
MemData_o  out  8  data byte (bit 0 = top pixel of the page)
MemWrite_o  out  1  one-cycle write strobe
DisplayOn_o  out  1  display enable (0xAE/0xAF)
Contrast_o  out  8  contrast register (0x81)
Invert_o  out  1  inverse display (0xA6/0xA7)

Behaviour:
- Reset (Reset=0 at a rising Clock edge): MemAddr_o=0, MemData_o=0, MemWrite_o=0, DisplayOn_o=0, Contrast_o=0x7F, Invert_o=0. Mode = page. Column range 0..COLUMNS-1. Page range 0..PAGES-1. Column and page pointers = 0. Decoder state = CMD. Bit counter = 0. Reset mid-byte or mid-command discards everything.
- Input capture: CS_i, SCK_i, MOSI_i and DC_i each pass through a 2-FF synchroniser. An SCK rising edge is detected on the synchronised signal, and MOSI/DC are sampled on that edge.
- Shift register: shifts MSB first. After the 8th edge, an internal byte strobe fires for one cycle.
- MemWrite_o latency: asserted exactly 1 Clock after the byte strobe.
- CS_i high: clears the bit counter, so a partial byte is dropped. Decoder state, pointers and registers are retained across CS toggles.
- Decoder FSM states: CMD, ARG1, ARG2.
  - CMD + command byte:
    - 0x00-0x0F: column pointer[3:0] = low nibble.
    - 0x10-0x1F: column pointer[7:4] = low nibble, truncated to COL_W bits.
    - 0xB0-0xBF: page pointer = low nibble, clamped to PAGES-1.
    - 0xAE/0xAF: set DisplayOn_o.
    - 0xA6/0xA7: set Invert_o.
    - 0x20, 0x81: go to ARG1.
    - 0x21, 0x22: go to ARG1, which then goes to ARG2.
    - Other bytes are ignored and the state stays CMD.
  - Arguments:
    - 0x20: bits[1:0] select mode: 00 horizontal, 01 vertical, 10 page. 11 leaves the mode unchanged.
    - 0x81: Contrast_o = argument.
    - 0x21 start/end: set the column range and move the column pointer to start.
    - 0x22 start/end: set the page range and move the page pointer to start.
    - Arguments above the maximum clamp to COLUMNS-1 or PAGES-1.
    - If end < start, end is forced to start.
  - Any data byte received in ARG1/ARG2 aborts the command (no register change), returns the FSM to CMD, and is processed as normal data.
- Data byte: MemData_o = byte, MemAddr_o = {page pointer, column pointer}, MemWrite_o=1 for one cycle. Pointers then advance in the same cycle:
  - Horizontal: at col_end, col wraps to col_start and page advances (page_end wraps to page_start); otherwise col+1.
  - Vertical: at page_end, page wraps to page_start and col advances (col_end wraps to col_start); otherwise page+1.
  - Page mode: at col_end, col wraps to col_start and page is unchanged; otherwise col+1.
- When not writing, MemAddr_o and MemData_o hold their last values.

Test Plan:
- Reset=0 for 2 cycles, then release → MemWrite_o=0, Contrast_o=0x7F, DisplayOn_o=0, Invert_o=0, MemAddr_o=0.
- Commands 0xAF, 0x81, 0x33, 0xA7 → DisplayOn_o=1, Contrast_o=0x33, Invert_o=1, and no MemWrite_o pulses.
- Commands 0x20,0x00, 0x21,0x7E,0x7F, 0x22,0x06,0x07, then 5 data bytes 0x01..0x05 → writes to addresses {6,126}, {6,127}, {7,126}, {7,127}, {6,126}. Each MemWrite_o occurs exactly 1 cycle after its byte strobe.
- Vertical mode (0x20,0x01), full ranges, 9 data bytes with PAGES=8 → pages 0..7 at col 0, then page 0 at col 1.
- Page mode: 0xB3, 0x0F, 0x17 set col 0x7F; 2 data bytes → {3,127}, then {3,0} (col_start=0), page still 3.
- CS_i raised after 5 bits, then a full byte 0xA5 with DC=1 → exactly one write with MemData_o=0xA5. In a second case, command 0x21 followed by a data byte → range unchanged and the byte is written.
